// File: rtl/fma16_pkg.sv
// fma16_pkg: operation type, flag bit positions, rounding modes and requester limit for fma16_arb
package fma16_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
    logic [1:0]  roundmode;
  } fma16_op_t;
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT = 0;
  localparam logic [1:0] RM_RZ = 2'd0;
  localparam logic [1:0] RM_RNE = 2'd1;
  localparam logic [1:0] RM_DN = 2'd2;
  localparam logic [1:0] RM_UP = 2'd3;
  localparam int MAX_NREQ = 4;
endpackage

// File: rtl/fma16.sv
// fma16: combinational FP16 fused multiply-add, (+/-)x*y (+/-)z with a single rounding
module fma16 import fma16_pkg::*; (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  // exact sum held in fixed point with LSB = 2^-48, the smallest product of two subnormals
  localparam int W = 82;
  logic [15:0] yy, zz;
  logic [4:0] ex, ey, ez;
  logic [10:0] mx, my, mz;
  logic [21:0] pm;
  logic [6:0] sh_p, k, lsb, ef;
  logic [W-1:0] p, zf, mag, rem, half;
  logic [9:0] qq;
  logic [16:0] big;
  logic sp, sz, sr, inexact, up, ovf, to_inf, tiny;
  logic xn, yn, zn, xi, yi, zi, xz, yz, snan, inv, nan;
  logic [15:0] fin_res;
  always_comb begin
    yy = mul ? y : 16'h3C00;
    zz = add ? z : 16'h0000;
    ex = x[14:10] | {4'b0, ~|x[14:10]};
    ey = yy[14:10] | {4'b0, ~|yy[14:10]};
    ez = zz[14:10] | {4'b0, ~|zz[14:10]};
    mx = {|x[14:10], x[9:0]};
    my = {|yy[14:10], yy[9:0]};
    mz = {|zz[14:10], zz[9:0]};
    sp = x[15] ^ yy[15] ^ negp;
    sz = zz[15] ^ negz;
    pm = 22'(mx) * 22'(my);
    sh_p = 7'(ex) + 7'(ey) - 7'd2;
    p = W'(pm) << sh_p;
    zf = W'(mz) << (7'(ez) + 7'd23);
    mag = (sp == sz) ? p + zf : (p >= zf) ? p - zf : zf - p;
    sr = (mag == '0) ? ((sp == sz) ? sp : roundmode == RM_DN) : ((sp == sz || p >= zf) ? sp : sz);
    k = '0;
    for (int i = 0; i < W; i++) if (mag[i]) k = 7'(i);
    tiny = k < 7'd34;
    lsb = tiny ? 7'd24 : k - 7'd10;
    ef = tiny ? 7'd0 : k - 7'd33;
    qq = 10'(mag >> lsb);
    rem = mag & ((W'(1) << lsb) - W'(1));
    half = W'(1) << (lsb - 7'd1);
    inexact = |rem;
    up = (roundmode == RM_RZ) ? 1'b0 :
         (roundmode == RM_RNE) ? (rem > half || (rem == half && qq[0])) :
         (roundmode == RM_UP) ? (!sr && inexact) : (sr && inexact);
    // the carry out of the fraction rolls straight into the exponent field
    big = {ef, qq} + 17'(up);
    ovf = big >= 17'h7C00;
    to_inf = roundmode == RM_RNE || (roundmode == RM_UP && !sr) || (roundmode == RM_DN && sr);
    fin_res = ovf ? {sr, to_inf ? 15'h7C00 : 15'h7BFF} : {sr, big[14:0]};
    xn = &x[14:10] & |x[9:0];
    yn = &yy[14:10] & |yy[9:0];
    zn = &zz[14:10] & |zz[9:0];
    xi = &x[14:10] & ~|x[9:0];
    yi = &yy[14:10] & ~|yy[9:0];
    zi = &zz[14:10] & ~|zz[9:0];
    xz = ~|x[14:0];
    yz = ~|yy[14:0];
    snan = (xn & ~x[9]) | (yn & ~yy[9]) | (zn & ~zz[9]);
    inv = snan | (xi & yz) | (yi & xz) | ((xi | yi) & zi & (sp != sz));
    nan = xn | yn | zn | inv;
    result = nan ? 16'h7E00 : (xi | yi) ? {sp, 15'h7C00} : zi ? {sz, 15'h7C00} : fin_res;
    flags = '0;
    flags[FLAG_INVALID] = inv;
    flags[FLAG_OVERFLOW] = !nan && !(xi | yi | zi) && ovf;
    flags[FLAG_UNDERFLOW] = !nan && !(xi | yi | zi) && tiny && inexact;
    flags[FLAG_INEXACT] = !nan && !(xi | yi | zi) && (inexact || ovf);
  end
endmodule

// File: rtl/fma16_rr_arb.sv
// fma16_rr_arb: one-hot round-robin grant, first asserted request strictly after last
module fma16_rr_arb #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant
);
  logic [IDW-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    // farthest candidate first so the nearest one after last overwrites it
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (req[idx]) grant = NREQ'(1) << idx;
    end
  end
endmodule

// File: rtl/fma16_arb.sv
// fma16_arb: round-robin issue of up to four requesters into one shared fma16,
// operand register (stage A) then result register (stage B) with backpressure
module fma16_arb import fma16_pkg::*; #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  fma16_op_t [NREQ-1:0]  req_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_result,
  output logic [3:0]            out_flags,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);
  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("fma16_arb: NREQ out of range");
  end
  logic a_valid, b_free, a_adv, a_free, accept;
  fma16_op_t a_op;
  logic [IDW-1:0] a_id, last, gid;
  logic [NREQ-1:0] grant;
  logic [15:0] res;
  logic [3:0] flg;
  fma16_rr_arb #(.NREQ(NREQ)) u_arb (.req(req_valid), .last(last), .grant(grant));
  fma16 u_fma (
    .x(a_op.x), .y(a_op.y), .z(a_op.z), .mul(a_op.mul), .add(a_op.add),
    .negp(a_op.negp), .negz(a_op.negz), .roundmode(a_op.roundmode),
    .result(res), .flags(flg)
  );
  always_comb begin
    b_free = !out_valid || out_ready;
    a_adv = a_valid && b_free;
    a_free = !a_valid || a_adv;
    req_ready = {NREQ{a_free && !reset}} & grant;
    accept = |req_ready;
    busy = a_valid || out_valid;
    gid = '0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) gid = IDW'(i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_op <= '0;
      a_id <= '0;
      last <= IDW'(NREQ - 1);
      out_valid <= 1'b0;
      out_result <= '0;
      out_flags <= '0;
      out_id <= '0;
    end else begin
      if (a_adv) begin
        out_result <= res;
        out_flags <= flg;
        out_id <= a_id;
      end
      if (b_free) out_valid <= a_valid;
      if (a_free) a_valid <= accept;
      if (accept) begin
        a_op <= req_op[gid];
        a_id <= gid;
        last <= gid;
      end
    end
  end
endmodule

// File: tb/tb_fma16_arb.sv
// tb_fma16_arb: directed checks of arbitration order, pipeline timing, backpressure, reset and arithmetic
module tb_fma16_arb;
  import fma16_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [1:0] rv, rr;
  fma16_op_t [1:0] ops;
  logic ordy, ov, bsy;
  logic [15:0] ores;
  logic [3:0] ofl;
  logic [0:0] oid;
  logic [3:0] rv4, rr4;
  fma16_op_t [3:0] ops4;
  logic ordy4, ov4, bsy4;
  logic [15:0] ores4;
  logic [3:0] ofl4;
  logic [1:0] oid4;
  int passed = 0;
  int total = 0;
  fma16_arb #(.NREQ(2)) dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_ready(rr), .req_op(ops),
    .out_valid(ov), .out_ready(ordy), .out_result(ores), .out_flags(ofl),
    .out_id(oid), .busy(bsy)
  );
  fma16_arb #(.NREQ(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rr4), .req_op(ops4),
    .out_valid(ov4), .out_ready(ordy4), .out_result(ores4), .out_flags(ofl4),
    .out_id(oid4), .busy(bsy4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic fma16_op_t mk(input logic [15:0] x, y, z, input logic mul, add, negz);
    mk = '{x: x, y: y, z: z, mul: mul, add: add, negp: 1'b0, negz: negz, roundmode: RM_RNE};
  endfunction
  fma16_op_t op_a, op_b, op_ov, op_f, op_s;
  initial begin
    op_a = mk(16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0);
    op_b = mk(16'h4000, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0);
    op_ov = mk(16'h7BFF, 16'h7BFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    op_f = mk(16'h3E00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b0);
    op_s = mk(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b1);
    reset = 1'b1; rv = '0; ordy = 1'b1; ops[0] = op_a; ops[1] = op_b;
    rv4 = '0; ops4 = '0; ordy4 = 1'b1;
    tick(); tick();
    rv = 2'b11; #1;
    chk("rst_ready", 32'(rr), 32'h0);
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_busy", 32'(bsy), 32'h0);
    chk("rst_result", 32'(ores), 32'h0);
    chk("rst_id", 32'(oid), 32'h0);
    tick(); reset = 1'b0; rv = '0;
    // single op from req0: 1.0 * 2.0
    tick(); rv = 2'b01; #1;
    chk("t1_ready", 32'(rr), 32'h1);
    tick(); rv = '0; #1;
    chk("t1_n1_valid", 32'(ov), 32'h0);
    chk("t1_n1_busy", 32'(bsy), 32'h1);
    tick(); #1;
    chk("t1_n2_valid", 32'(ov), 32'h1);
    chk("t1_result", 32'(ores), 32'h4000);
    chk("t1_flags", 32'(ofl), 32'h0);
    chk("t1_id", 32'(oid), 32'h0);
    tick(); #1;
    chk("t1_drained", 32'(bsy), 32'h0);
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    // both requesters continuously valid: strict alternation starting at req0
    for (int i = 0; i < 6; i++) begin
      tick(); rv = 2'b11; #1;
      chk("t2_ready", 32'(rr), (i % 2) ? 32'h2 : 32'h1);
      if (i >= 2) begin
        chk("t2_valid", 32'(ov), 32'h1);
        chk("t2_id", 32'(oid), 32'(i % 2));
        chk("t2_result", 32'(ores), (i % 2) ? 32'h4400 : 32'h4000);
      end
    end
    tick(); rv = '0; reset = 1'b1; tick(); reset = 1'b0;
    // backpressure: five stalled cycles, exactly two accepts
    tick(); rv = 2'b11; ordy = 1'b0; #1;
    chk("t3_c0_ready", 32'(rr), 32'h1);
    tick(); #1;
    chk("t3_c1_ready", 32'(rr), 32'h2);
    for (int i = 2; i < 5; i++) begin
      tick(); #1;
      chk("t3_full_ready", 32'(rr), 32'h0);
      chk("t3_hold_valid", 32'(ov), 32'h1);
      chk("t3_hold_result", 32'(ores), 32'h4000);
      chk("t3_hold_id", 32'(oid), 32'h0);
    end
    tick(); ordy = 1'b1; #1;
    chk("t3_release_ready", 32'(rr), 32'h1);
    chk("t3_release_id", 32'(oid), 32'h0);
    tick(); rv = '0; #1;
    chk("t3_d1_id", 32'(oid), 32'h1);
    chk("t3_d1_result", 32'(ores), 32'h4400);
    tick(); #1;
    chk("t3_d2_valid", 32'(ov), 32'h1);
    chk("t3_d2_id", 32'(oid), 32'h0);
    tick(); #1;
    chk("t3_empty", 32'(ov), 32'h0);
    // single bubble: B stalled with A empty still accepts
    tick(); rv = 2'b01; ordy = 1'b0; #1;
    chk("t3b_ready0", 32'(rr), 32'h1);
    tick(); rv = '0;
    tick(); rv = 2'b10; #1;
    chk("t3b_stalled", 32'(ov), 32'h1);
    chk("t3b_bubble_ready", 32'(rr), 32'h2);
    tick(); rv = '0; ordy = 1'b1; #1;
    chk("t3b_id0", 32'(oid), 32'h0);
    tick(); #1;
    chk("t3b_id1", 32'(oid), 32'h1);
    chk("t3b_res1", 32'(ores), 32'h4400);
    // arithmetic: overflow, fma, subtraction through negz
    tick(); ops[0] = op_ov; rv = 2'b01; #1;
    chk("t4_ready_ov", 32'(rr), 32'h1);
    tick(); ops[1] = op_f; rv = 2'b10; #1;
    chk("t4_ready_f", 32'(rr), 32'h2);
    tick(); ops[0] = op_s; rv = 2'b01; #1;
    chk("t4_ready_s", 32'(rr), 32'h1);
    chk("t4_ov_result", 32'(ores), 32'h7C00);
    chk("t4_ov_flags", 32'(ofl), 32'h5);
    tick(); rv = '0; #1;
    chk("t4_fma_result", 32'(ores), 32'h4400);
    chk("t4_fma_flags", 32'(ofl), 32'h0);
    chk("t4_fma_id", 32'(oid), 32'h1);
    tick(); #1;
    chk("t4_sub_result", 32'(ores), 32'h3C00);
    chk("t4_sub_flags", 32'(ofl), 32'h0);
    // reset with both stages full discards everything in flight
    ops[0] = op_a; ops[1] = op_b;
    tick(); rv = 2'b11; ordy = 1'b0;
    tick();
    tick(); #1;
    chk("t5_full_ready", 32'(rr), 32'h0);
    chk("t5_full_busy", 32'(bsy), 32'h1);
    tick(); reset = 1'b1; rv = '0; #1;
    chk("t5_in_reset_ready", 32'(rr), 32'h0);
    tick(); reset = 1'b0; #1;
    chk("t5_post_valid", 32'(ov), 32'h0);
    chk("t5_post_busy", 32'(bsy), 32'h0);
    chk("t5_post_ready", 32'(rr), 32'h0);
    tick(); ops[0] = op_f; ops[1] = op_s; rv = 2'b11; ordy = 1'b1; #1;
    chk("t5_first_grant", 32'(rr), 32'h1);
    tick(); rv = 2'b10; #1;
    chk("t5_second_grant", 32'(rr), 32'h2);
    chk("t5_no_stale", 32'(ov), 32'h0);
    tick(); rv = '0; #1;
    chk("t5_r0_result", 32'(ores), 32'h4400);
    chk("t5_r0_id", 32'(oid), 32'h0);
    tick(); #1;
    chk("t5_r1_result", 32'(ores), 32'h3C00);
    chk("t5_r1_id", 32'(oid), 32'h1);
    // four requesters: pointer wrap and skip
    tick(); rv4 = 4'b0010; #1;
    chk("t6_g1", 32'(rr4), 32'h2);
    tick(); rv4 = 4'b1010; #1;
    chk("t6_g3", 32'(rr4), 32'h8);
    tick(); rv4 = 4'b0011; #1;
    chk("t6_g0", 32'(rr4), 32'h1);
    chk("t6_out1", 32'(oid4), 32'h1);
    chk("t6_res", 32'(ores4), 32'h0);
    tick(); rv4 = 4'b0010; #1;
    chk("t6_g1b", 32'(rr4), 32'h2);
    chk("t6_out3", 32'(oid4), 32'h3);
    tick(); rv4 = '0; #1;
    chk("t6_out0", 32'(oid4), 32'h0);
    tick(); #1;
    chk("t6_out1b", 32'(oid4), 32'h1);
    chk("t6_flags", 32'(ofl4), 32'h0);
    tick(); #1;
    chk("t6_empty", 32'(ov4), 32'h0);
    chk("t6_idle", 32'(bsy4), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
